l2_frontend_rd_arb: RTL
=======================

Name: l2_frontend_rd_arb

Overview:
- Round-robin read arbiter that shares the core's single L2 front-end AXI4 slave port among NumReq requesters, such as the debug DMA and the boot loader.
- Only the AR and R channels are arbitrated; the write channels are out of scope and stay tied off at the core.
- At most one read burst is in flight at a time, so R routing is deterministic.
- A watchdog flags a burst that stalls on the front-end port.

Parameters:
NumReq, 2, number of requesters (>=2)
AddrWidth, 64, AXI address width
DataWidth, 64, AXI data width
IdWidth, 4, requester-side ID width; master-side ID is IdWidth+IdxW, where IdxW=$clog2(NumReq)
TimeoutCycles, 1024, stall cycles before timeout_o asserts

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
req_ar_valid  in  NumReq  per-requester AR valid
req_ar_ready  out  NumReq  per-requester AR ready
req_ar_addr  in  NumReq*AddrWidth  packed addresses
req_ar_len  in  NumReq*8  packed burst lengths
req_ar_size  in  NumReq*3  packed sizes
req_ar_burst  in  NumReq*2  packed burst types
req_ar_id  in  NumReq*IdWidth  packed IDs
req_r_valid  out  NumReq  R valid, winner only
req_r_ready  in  NumReq  R ready
req_r_data  out  DataWidth  broadcast R data
req_r_resp  out  2  broadcast R resp
req_r_last  out  1  broadcast R last
req_r_id  out  IdWidth  m_r_id lower IdWidth bits
m_ar_valid  out  1  front-end AR valid
m_ar_ready  in  1  front-end AR ready
m_ar_addr  out  AddrWidth  AR address
m_ar_len  out  8  AR burst length
m_ar_size  out  3  AR size
m_ar_burst  out  2  AR burst type
m_ar_id  out  IdWidth+IdxW  {winner index, requester ID}
m_ar_lock  out  1  constant 0
m_ar_cache  out  4  constant 4'b0010
m_ar_prot  out  3  constant 3'b000
m_ar_qos  out  4  constant 0
m_r_valid  in  1  R valid
m_r_ready  out  1  R ready
m_r_data  in  DataWidth  R data
m_r_resp  in  2  R resp
m_r_last  in  1  R last
m_r_id  in  IdWidth+IdxW  R id
busy  out  1  high when state != IDLE
grant_idx  out  IdxW  registered winner index
timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async assert, clk-synchronous deassert expected):
  - state=IDLE, rr_ptr=0, grant_idx=0, stall_cnt=0.
  - timeout=0, m_ar_valid=0, m_r_ready=0.
  - All req_ar_ready=0 and req_r_valid=0.
  - Captured AR registers reset to 0.
- States: IDLE, ADDR, DATA.
- IDLE:
  - Winner = first i with req_ar_valid[i], searching from rr_ptr upward and wrapping modulo NumReq.
  - req_ar_ready[winner]=1 combinationally; all other readies are 0.
  - On the handshake: capture addr/len/size/burst/id and grant_idx=winner; rr_ptr=(winner+1) mod NumReq; next state ADDR.
  - With no valid requester, stay in IDLE and leave rr_ptr unchanged.
- ADDR:
  - m_ar_valid=1, driven from the captured registers; fields stay stable until m_ar_ready.
  - On m_ar_ready, go to DATA. The first m_ar_valid appears exactly 1 cycle after the requester handshake.
- DATA:
  - req_r_valid[grant_idx]=m_r_valid and m_r_ready=req_r_ready[grant_idx]; other req_r_valid are 0.
  - On a beat with m_r_valid&&m_r_ready&&m_r_last, go to IDLE. Arbitration for the next burst happens in that IDLE cycle, giving 1 idle cycle between bursts.
  - R routing is by grant_idx. m_r_id upper bits are not checked.
- req_r_data/resp/last/id are always combinational copies of m_r_*.
- req_ar_ready is 0 in ADDR and DATA. Requests arriving then wait and are not dropped (AXI valid is sticky).
- Watchdog:
  - stall_cnt increments each cycle in ADDR/DATA with no m_ar or m_r handshake.
  - It clears on any handshake or on entry to IDLE, and saturates at TimeoutCycles.
  - When stall_cnt reaches TimeoutCycles, timeout is set. It is sticky until reset and does not alter the FSM.
- Simultaneous requests: strictly round-robin, with no requester starved for more than NumReq-1 bursts.
- len=0 (single beat): the DATA state lasts until that single last beat.
- A reset mid-burst abandons the transaction. The integrator must reset the front-end port in the same domain.

Test Plan:
- Single requester 0, addr 0x8000_0000, len=3, id=5 → m_ar_valid 1 cycle after the handshake; m_ar_id={0,5}; 4 beats routed to req_r_valid[0] only; busy falls after the last beat.
- Req0 and req1 valid together, held for 4 bursts from reset → grant order 0,1,0,1; grant_idx and rr_ptr alternate.
- m_ar_ready held low 5 cycles → m_ar_addr/len/size/burst/id stable all 5 cycles; req_ar_ready stays 0; no second grant.
- Winner's req_r_ready toggling 1,0,1 against constant m_r_valid → m_r_ready mirrors it; no beat lost or duplicated; data order preserved.
- TimeoutCycles=16, m_r_valid never asserted after AR → timeout rises exactly 16 cycles after the AR handshake and remains set; a later burst completes normally with timeout still 1.
- rst_n asserted mid-DATA → outputs return to reset values asynchronously, without waiting for a clk edge; after release, req1 pending → granted first (rr_ptr=0, search from 0: req0 idle, so req1).

Source files
------------

// File: rtl/l2_frontend_rd_arb.sv
// Round-robin read arbiter sharing the core's L2 front-end AXI4 read port (AR/R only).
// One burst in flight at a time; a sticky watchdog flags a burst stalled on the port.
//
// state | meaning
// IDLE  | arbitrate; winner's AR ready asserted combinationally, capture on handshake
// ADDR  | captured AR presented on m_ar_*, held until m_ar_ready
// DATA  | R beats routed to grant_idx until the last beat is accepted
module l2_frontend_rd_arb #(
   parameter int NumReq         = 2,
   parameter int AddrWidth      = 64,
   parameter int DataWidth      = 64,
   parameter int IdWidth        = 4,
   parameter int TimeoutCycles  = 1024,
   localparam int IdxW          = $clog2(NumReq)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NumReq-1:0]              req_ar_valid,
   output logic [NumReq-1:0]              req_ar_ready,
   input  logic [NumReq*AddrWidth-1:0]    req_ar_addr,
   input  logic [NumReq*8-1:0]            req_ar_len,
   input  logic [NumReq*3-1:0]            req_ar_size,
   input  logic [NumReq*2-1:0]            req_ar_burst,
   input  logic [NumReq*IdWidth-1:0]      req_ar_id,
   output logic [NumReq-1:0]              req_r_valid,
   input  logic [NumReq-1:0]              req_r_ready,
   output logic [DataWidth-1:0]           req_r_data,
   output logic [1:0]                     req_r_resp,
   output logic                           req_r_last,
   output logic [IdWidth-1:0]             req_r_id,
   output logic                           m_ar_valid,
   input  logic                           m_ar_ready,
   output logic [AddrWidth-1:0]           m_ar_addr,
   output logic [7:0]                     m_ar_len,
   output logic [2:0]                     m_ar_size,
   output logic [1:0]                     m_ar_burst,
   output logic [IdWidth+IdxW-1:0]        m_ar_id,
   output logic                           m_ar_lock,
   output logic [3:0]                     m_ar_cache,
   output logic [2:0]                     m_ar_prot,
   output logic [3:0]                     m_ar_qos,
   input  logic                           m_r_valid,
   output logic                           m_r_ready,
   input  logic [DataWidth-1:0]           m_r_data,
   input  logic [1:0]                     m_r_resp,
   input  logic                           m_r_last,
   input  logic [IdWidth+IdxW-1:0]        m_r_id,
   output logic                           busy,
   output logic [IdxW-1:0]                grant_idx,
   output logic                           timeout
);

   localparam int CntW = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t                 state;
   logic [IdxW-1:0]        rr_ptr;
   logic [IdxW-1:0]        win_idx;
   logic [IdxW-1:0]        cand;
   logic                   win_found;
   logic [IdWidth-1:0]     cap_id;
   logic [CntW-1:0]        stall_cnt;
   logic [CntW-1:0]        stall_nxt;
   logic                   hs_any;
   logic                   unused_r_id_hi;

   // Walk from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = NumReq - 1; k >= 0; k--) begin
         cand = IdxW'((int'(rr_ptr) + k) % NumReq);
         if (req_ar_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      req_ar_ready = '0;
      if (rst_n && state == IDLE && win_found) req_ar_ready[win_idx] = 1'b1;
   end

   always_comb begin
      req_r_valid = '0;
      if (state == DATA) req_r_valid[grant_idx] = m_r_valid;
   end

   assign m_r_ready  = (state == DATA) && req_r_ready[grant_idx];
   assign m_ar_id    = {grant_idx, cap_id};
   assign m_ar_lock  = 1'b0;
   assign m_ar_cache = 4'b0010;
   assign m_ar_prot  = 3'b000;
   assign m_ar_qos   = 4'b0000;
   assign busy       = (state != IDLE);

   assign req_r_data = m_r_data;
   assign req_r_resp = m_r_resp;
   assign req_r_last = m_r_last;
   assign req_r_id   = m_r_id[IdWidth-1:0];
   assign unused_r_id_hi = ^m_r_id[IdWidth+IdxW-1:IdWidth];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         grant_idx  <= '0;
         m_ar_valid <= 1'b0;
         m_ar_addr  <= '0;
         m_ar_len   <= '0;
         m_ar_size  <= '0;
         m_ar_burst <= '0;
         cap_id     <= '0;
      end else begin
         unique case (state)
            IDLE: if (win_found) begin
               m_ar_addr  <= req_ar_addr[win_idx*AddrWidth +: AddrWidth];
               m_ar_len   <= req_ar_len[win_idx*8 +: 8];
               m_ar_size  <= req_ar_size[win_idx*3 +: 3];
               m_ar_burst <= req_ar_burst[win_idx*2 +: 2];
               cap_id     <= req_ar_id[win_idx*IdWidth +: IdWidth];
               grant_idx  <= win_idx;
               rr_ptr     <= (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + IdxW'(1);
               m_ar_valid <= 1'b1;
               state      <= ADDR;
            end
            ADDR: if (m_ar_ready) begin
               m_ar_valid <= 1'b0;
               state      <= DATA;
            end
            DATA: if (m_r_valid && m_r_ready && m_r_last) state <= IDLE;
            default: begin
               m_ar_valid <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

   assign hs_any = (m_ar_valid && m_ar_ready) || (m_r_valid && m_r_ready);

   always_comb begin
      stall_nxt = stall_cnt;
      if (state == IDLE || hs_any) stall_nxt = '0;
      else if (stall_cnt != CntMax) stall_nxt = stall_cnt + CntW'(1);
   end

   // Watchdog only observes; the burst is never aborted by it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         timeout   <= 1'b0;
      end else begin
         stall_cnt <= stall_nxt;
         if (stall_nxt == CntMax) timeout <= 1'b1;
      end
   end

endmodule
